mem_gate: RTL and testbench
===========================

# mem_gate

Address-decoding gate between the `jay` core's `l1_to_mem__*` port and the `mem` word array (64-bit words, 8192 deep). It forwards in-range accesses to `mem` unchanged. It also:
- implements a `tohost` result register and a free-running cycle counter as memory-mapped words;
- flags out-of-range accesses;
- optionally runs a watchdog.

Benches and top levels read `done`/`result` from ports instead of probing register-file internals.

## Interface
- `ADDR_W`, 61, word-address width from L1
- `DATA_W`, 64, data word width
- `DEPTH__LOG2`, 13, `mem` index width
- `TOHOST_ADDR`, 61'h0200_0000, word address of the result register
- `CYCLE_ADDR`, 61'h0200_0001, word address of the read-only cycle counter
- `TIMEOUT`, 200000, watchdog limit in cycles (used only with the watchdog)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `l1_to_mem__addr`  in  ADDR_W  word address
- `l1_to_mem__wr_data`  in  DATA_W  write data
- `l1_to_mem__rd_data`  out  DATA_W  read data, valid one cycle after the read request
- `l1_to_mem__en`  in  1  access strobe
- `l1_to_mem__we`  in  1  write when 1, read when 0
- `mem__addr`  out  DEPTH__LOG2  `l1_to_mem__addr[DEPTH__LOG2-1:0]`
- `mem__wr_data`  out  DATA_W  passthrough
- `mem__rd_data`  in  DATA_W  `mem` read data, one-cycle latency
- `mem__en`  out  1  gated strobe
- `mem__we`  out  1  passthrough
- `done`  out  1  sticky, set by the first `tohost` write
- `result`  out  DATA_W  data from the first `tohost` write
- `err`  out  1  sticky out-of-range flag
- `err_addr`  out  ADDR_W  address of the first out-of-range access
- `timeout`  out  1  sticky watchdog flag

## Operation
- **Classification** (combinational on `l1_to_mem__addr`):
  - MEM when `addr[ADDR_W-1:DEPTH__LOG2]==0`
  - TOHOST when `addr==TOHOST_ADDR`
  - CYCLE when `addr==CYCLE_ADDR`
  - BAD otherwise
- **FSM states:** RUN (reset state), DONE, HUNG. DONE and HUNG are terminal until reset.
  - `done` = (state==DONE); `timeout` = (state==HUNG).
- **Gating:** `mem__en = l1_to_mem__en & MEM & state==RUN & rst`. No access has any side effect outside RUN.
- **TOHOST write in RUN:** `result<=wr_data`; RUN->DONE. A TOHOST read returns `result`.
- **CYCLE:** reads return the counter value sampled in the request cycle. Writes are ignored.
- **BAD access in RUN:** `err<=1`. `err_addr` is captured only when `err` was 0. Reads return 64'hDEAD_BEEF_DEAD_BEEF.
- **Cycle counter:** 64-bit; counts every cycle out of reset in every state; wraps 2^64-1 -> 0.
- **Read return:** each read request registers its class and a valid bit.
  - Next cycle `l1_to_mem__rd_data` = `mem__rd_data` / `result` / snapshot / BAD pattern, according to the registered class.
  - `l1_to_mem__rd_data` is 0 when the previous cycle had no read, or when the read was issued outside RUN.
- **Back-to-back** reads of mixed classes are supported every cycle. No stalls.

## Timing
- Read latency is exactly 1 cycle. A write completes in its request cycle.
- `done`/`result`/`err`/`err_addr` update at the edge ending the request cycle.
- **Reset values:** `done`/`err`/`timeout` = 0; `result`/`err_addr`/`l1_to_mem__rd_data`/counters = 0; `mem__en`=0 while `rst` is low.
- **Same-cycle TOHOST write and watchdog expiry:** DONE wins.
- **Reset mid-operation:** all state clears asynchronously. A read pending across reset returns 0.

## Configuration
- Macro: `MEM_GATE_WATCHDOG_EN`.
- **With the macro:**
  - A watchdog counter increments in RUN.
  - When it equals `TIMEOUT-1` and no TOHOST write occurs that cycle, the FSM goes RUN->HUNG.
  - The counter then freezes.
- **Without the macro:**
  - No watchdog counter.
  - `timeout` is tied 0 and HUNG is unreachable.
  - `TIMEOUT` is unused.

## Structure
- `mem_gate_pkg` holds:
  - class enum `{CLS_MEM, CLS_TOHOST, CLS_CYCLE, CLS_BAD}`
  - state enum `{ST_RUN, ST_DONE, ST_HUNG}`
  - `BAD_DATA` constant
- One sub-module, `mem_gate_decode`: the combinational address classifier, parameterised like `mem_gate`.

## Test plan
- Write 0x1122334455667788 to word 5, then read word 5 -> `mem__en` high both cycles; read data 0x1122334455667788 one cycle after the read.
- Write 0x2A to `TOHOST_ADDR` -> `done`=1 and `result`=0x2A next cycle. A second TOHOST write of 0x99 leaves `result`=0x2A. A subsequent MEM write produces `mem__en`=0.
- Read `addr=61'h4000`, then write `61'h5000` -> read returns 0xDEADBEEFDEADBEEF; `err`=1; `err_addr`=0x4000 (not 0x5000); `mem__en` stays 0.
- Release reset, then read `CYCLE_ADDR` in the 10th cycle out of reset -> returns 9. A back-to-back MEM read the next cycle returns mem data.
- With `MEM_GATE_WATCHDOG_EN` and `TIMEOUT`=100, no TOHOST write -> `timeout`=1 after exactly 100 RUN cycles. Repeat with the TOHOST write in cycle 99 -> `done`=1, `timeout`=0.
- Assert `rst` low while a read is in flight -> all outputs 0 immediately; rd_data 0 after release.

Source files
------------

// File: rtl/mem_gate_pkg.sv
// Shared types for mem_gate: access classes, FSM states and the bad-read pattern.
package mem_gate_pkg;

  typedef enum logic [1:0] {
    CLS_MEM,
    CLS_TOHOST,
    CLS_CYCLE,
    CLS_BAD
  } cls_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DONE,
    ST_HUNG
  } state_e;

  localparam logic [63:0] BAD_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/mem_gate_decode.sv
// Combinational address classifier for mem_gate: MEM, TOHOST, CYCLE or BAD.
module mem_gate_decode
  import mem_gate_pkg::*;
#(
  parameter int              ADDR_W      = 61,
  parameter int              DEPTH__LOG2 = 13,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 61'h0200_0000,
  parameter logic [ADDR_W-1:0] CYCLE_ADDR  = 61'h0200_0001
) (
  input  logic [ADDR_W-1:0] addr,
  output cls_e              cls
);

  // MEM is checked first; the mapped words sit far above the array so they never overlap it.
  always_comb begin
    cls = CLS_BAD;
    if (addr[ADDR_W-1:DEPTH__LOG2] == '0) begin
      cls = CLS_MEM;
    end else if (addr == TOHOST_ADDR) begin
      cls = CLS_TOHOST;
    end else if (addr == CYCLE_ADDR) begin
      cls = CLS_CYCLE;
    end
  end

endmodule

// File: rtl/mem_gate.sv
// Address gate between the L1 port and the mem array with tohost/cycle words and error capture.
// Optional watchdog is enabled by defining MEM_GATE_WATCHDOG_EN.
module mem_gate
  import mem_gate_pkg::*;
#(
  parameter int                ADDR_W      = 61,
  parameter int                DATA_W      = 64,
  parameter int                DEPTH__LOG2 = 13,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 61'h0200_0000,
  parameter logic [ADDR_W-1:0] CYCLE_ADDR  = 61'h0200_0001,
  parameter int                TIMEOUT     = 200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      l1_to_mem__addr,
  input  logic [DATA_W-1:0]      l1_to_mem__wr_data,
  output logic [DATA_W-1:0]      l1_to_mem__rd_data,
  input  logic                   l1_to_mem__en,
  input  logic                   l1_to_mem__we,
  output logic [DEPTH__LOG2-1:0] mem__addr,
  output logic [DATA_W-1:0]      mem__wr_data,
  input  logic [DATA_W-1:0]      mem__rd_data,
  output logic                   mem__en,
  output logic                   mem__we,
  output logic                   done,
  output logic [DATA_W-1:0]      result,
  output logic                   err,
  output logic [ADDR_W-1:0]      err_addr,
  output logic                   timeout
);

  cls_e              cls;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [63:0]       snap_q, snap_d;
  logic              rd_valid_q, rd_valid_d;
  cls_e              rd_cls_q, rd_cls_d;
  logic              in_run;
  logic              tohost_wr;
  logic              bad_acc;
  logic              hang_go;

  mem_gate_decode #(
    .ADDR_W      (ADDR_W),
    .DEPTH__LOG2 (DEPTH__LOG2),
    .TOHOST_ADDR (TOHOST_ADDR),
    .CYCLE_ADDR  (CYCLE_ADDR)
  ) u_decode (
    .addr (l1_to_mem__addr),
    .cls  (cls)
  );

  assign in_run    = (state_q == ST_RUN);
  assign tohost_wr = l1_to_mem__en & l1_to_mem__we & (cls == CLS_TOHOST) & in_run;
  assign bad_acc   = l1_to_mem__en & (cls == CLS_BAD) & in_run;

  assign mem__addr    = l1_to_mem__addr[DEPTH__LOG2-1:0];
  assign mem__wr_data = l1_to_mem__wr_data;
  assign mem__we      = l1_to_mem__we;
  assign mem__en      = l1_to_mem__en & (cls == CLS_MEM) & in_run & rst;

`ifdef MEM_GATE_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts only in RUN, so it freezes once the FSM leaves RUN.
  always_comb begin
    wd_d = wd_q;
    if (in_run) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign hang_go = in_run & (wd_q == WD_W'(TIMEOUT - 1)) & ~tohost_wr;
`else
  assign hang_go = 1'b0;
`endif

  // A tohost write beats a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (tohost_wr) begin
        state_d = ST_DONE;
      end else if (hang_go) begin
        state_d = ST_HUNG;
      end
    end
  end

  always_comb begin
    result_d   = result_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    cycle_d    = cycle_q + 64'd1;
    snap_d     = cycle_q;
    rd_valid_d = l1_to_mem__en & ~l1_to_mem__we & in_run;
    rd_cls_d   = cls;
    if (tohost_wr) begin
      result_d = l1_to_mem__wr_data;
    end
    if (bad_acc) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = l1_to_mem__addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      result_q   <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cycle_q    <= '0;
      snap_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_cls_q   <= CLS_MEM;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cycle_q    <= cycle_d;
      snap_q     <= snap_d;
      rd_valid_q <= rd_valid_d;
      rd_cls_q   <= rd_cls_d;
    end
  end

  always_comb begin
    l1_to_mem__rd_data = '0;
    if (rd_valid_q) begin
      case (rd_cls_q)
        CLS_MEM:    l1_to_mem__rd_data = mem__rd_data;
        CLS_TOHOST: l1_to_mem__rd_data = result_q;
        CLS_CYCLE:  l1_to_mem__rd_data = DATA_W'(snap_q);
        default:    l1_to_mem__rd_data = DATA_W'(BAD_DATA);
      endcase
    end
  end

  assign done     = (state_q == ST_DONE);
  assign timeout  = (state_q == ST_HUNG);
  assign result   = result_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_gate.sv
// Directed self-checking bench for mem_gate with a behavioural one-cycle-latency mem array.
// Watchdog steps run only when MEM_GATE_WATCHDOG_EN is defined.
module tb_mem_gate;

  localparam logic [60:0] TOHOST = 61'h0200_0000;
  localparam logic [60:0] CYC    = 61'h0200_0001;

  logic        clk;
  logic        rst;
  logic [60:0] l1_addr;
  logic [63:0] l1_wr_data;
  logic [63:0] l1_rd_data;
  logic        l1_en;
  logic        l1_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [63:0] mem_rd_data;
  logic        mem_en;
  logic        mem_we;
  logic        done;
  logic [63:0] result;
  logic        err;
  logic [60:0] err_addr;
  logic        timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] mem_array [0:8191];

  mem_gate #(
    .TIMEOUT (100)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .l1_to_mem__addr    (l1_addr),
    .l1_to_mem__wr_data (l1_wr_data),
    .l1_to_mem__rd_data (l1_rd_data),
    .l1_to_mem__en      (l1_en),
    .l1_to_mem__we      (l1_we),
    .mem__addr          (mem_addr),
    .mem__wr_data       (mem_wr_data),
    .mem__rd_data       (mem_rd_data),
    .mem__en            (mem_en),
    .mem__we            (mem_we),
    .done               (done),
    .result             (result),
    .err                (err),
    .err_addr           (err_addr),
    .timeout            (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem_array[mem_addr];
    end
  end

  task automatic applyStimulus(input logic en, input logic we, input logic [60:0] addr,
                               input logic [63:0] wd);
    l1_en      = en;
    l1_we      = we;
    l1_addr    = addr;
    l1_wr_data = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 61'd5, 64'd0);
    #3;
    checkOutput("reset_mem_en", {63'd0, mem_en}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_err", {63'd0, err}, 64'd0);
    checkOutput("reset_timeout", {63'd0, timeout}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_err_addr", {3'd0, err_addr}, 64'd0);
    checkOutput("reset_rd_data", l1_rd_data, 64'd0);

    // Cycle 1 out of reset starts here; counter reads 0 during it.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 61'd7, 64'hA5A5_0000_1234_5678);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 61'd0, 64'd0);
    end
    applyStimulus(1'b1, 1'b0, CYC, 64'd0);
    #1 checkOutput("cycle_rd_mem_en", {63'd0, mem_en}, 64'd0);
    @(negedge clk);
    checkOutput("cycle_rd_data", l1_rd_data, 64'd9);
    applyStimulus(1'b1, 1'b0, 61'd7, 64'd0);
    #1 checkOutput("b2b_mem_en", {63'd0, mem_en}, 64'd1);
    @(negedge clk);
    checkOutput("b2b_rd_data", l1_rd_data, 64'hA5A5_0000_1234_5678);

    applyStimulus(1'b1, 1'b1, 61'd5, 64'h1122_3344_5566_7788);
    #1 checkOutput("wr5_mem_en", {63'd0, mem_en}, 64'd1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 61'd5, 64'd0);
    #1 checkOutput("rd5_mem_en", {63'd0, mem_en}, 64'd1);
    @(negedge clk);
    checkOutput("rd5_data", l1_rd_data, 64'h1122_3344_5566_7788);
    applyStimulus(1'b0, 1'b0, 61'd0, 64'd0);
    @(negedge clk);
    checkOutput("idle_rd_data", l1_rd_data, 64'd0);

    applyStimulus(1'b1, 1'b0, 61'h4000, 64'd0);
    #1 checkOutput("bad_rd_mem_en", {63'd0, mem_en}, 64'd0);
    @(negedge clk);
    checkOutput("bad_rd_data", l1_rd_data, 64'hDEAD_BEEF_DEAD_BEEF);
    checkOutput("bad_err", {63'd0, err}, 64'd1);
    checkOutput("bad_err_addr", {3'd0, err_addr}, 64'h4000);
    applyStimulus(1'b1, 1'b1, 61'h5000, 64'h55);
    #1 checkOutput("bad_wr_mem_en", {63'd0, mem_en}, 64'd0);
    @(negedge clk);
    checkOutput("bad_err_addr_kept", {3'd0, err_addr}, 64'h4000);
    checkOutput("pre_tohost_done", {63'd0, done}, 64'd0);

    applyStimulus(1'b1, 1'b1, TOHOST, 64'h2A);
    @(negedge clk);
    checkOutput("tohost_done", {63'd0, done}, 64'd1);
    checkOutput("tohost_result", result, 64'h2A);
    applyStimulus(1'b1, 1'b1, TOHOST, 64'h99);
    @(negedge clk);
    checkOutput("tohost_second_result", result, 64'h2A);
    applyStimulus(1'b1, 1'b0, TOHOST, 64'd0);
    @(negedge clk);
    checkOutput("done_rd_data", l1_rd_data, 64'd0);
    applyStimulus(1'b1, 1'b1, 61'd6, 64'h66);
    #1 checkOutput("done_mem_en", {63'd0, mem_en}, 64'd0);
    checkOutput("done_timeout", {63'd0, timeout}, 64'd0);

    // Asynchronous reset from DONE with err set must clear everything at once.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("arst_done", {63'd0, done}, 64'd0);
    checkOutput("arst_err", {63'd0, err}, 64'd0);
    checkOutput("arst_result", result, 64'd0);
    checkOutput("arst_err_addr", {3'd0, err_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 61'd5, 64'd0);
    @(negedge clk);
    checkOutput("inflight_rd_data", l1_rd_data, 64'h1122_3344_5566_7788);
    rst = 1'b0;
    #1;
    checkOutput("inflight_arst_rd_data", l1_rd_data, 64'd0);
    checkOutput("inflight_arst_mem_en", {63'd0, mem_en}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 61'd0, 64'd0);
    @(negedge clk);
    checkOutput("post_release_rd_data", l1_rd_data, 64'd0);

`ifdef MEM_GATE_WATCHDOG_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 99; i++) @(negedge clk);
    checkOutput("wd_99_timeout", {63'd0, timeout}, 64'd0);
    @(negedge clk);
    checkOutput("wd_100_timeout", {63'd0, timeout}, 64'd1);
    checkOutput("wd_100_done", {63'd0, done}, 64'd0);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 98; i++) @(negedge clk);
    applyStimulus(1'b1, 1'b1, TOHOST, 64'h77);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 61'd0, 64'd0);
    checkOutput("wd_tohost_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wd_tohost_timeout", {63'd0, timeout}, 64'd0);
    checkOutput("wd_tohost_result", result, 64'h77);
`else
    for (int i = 0; i < 120; i++) @(negedge clk);
    checkOutput("nowd_timeout", {63'd0, timeout}, 64'd0);
`endif

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
